// File: rtl/key_load_ctrl.sv
// key_load_ctrl: receives a serial key plus an even-parity bit and presents a
// parity-checked key to a logic-locked core. Repeated parity failures lock the
// block out until reset. Partial or failed keys are never driven onto key_out.
module key_load_ctrl #(
  parameter int unsigned KEY_W    = 8,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_sen,
  input  logic             key_sdi,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             load_err,
  output logic             lockout
);

  localparam int unsigned CNT_W  = $clog2(KEY_W + 1);
  localparam int unsigned FAIL_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    VALID   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t             state, stateNxt;
  logic [KEY_W-1:0]   shiftReg, shiftNxt;
  logic [CNT_W-1:0]   bitCnt, bitCntNxt;
  logic [FAIL_W-1:0]  failCnt, failCntNxt;
  logic               parityBit, parityNxt;
  logic [KEY_W-1:0]   keyOutNxt;
  logic               keyValidNxt, busyNxt, loadErrNxt, lockoutNxt;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      failCnt   <= '0;
      parityBit <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      load_err  <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= stateNxt;
      shiftReg  <= shiftNxt;
      bitCnt    <= bitCntNxt;
      failCnt   <= failCntNxt;
      parityBit <= parityNxt;
      key_out   <= keyOutNxt;
      key_valid <= keyValidNxt;
      busy      <= busyNxt;
      load_err  <= loadErrNxt;
      lockout   <= lockoutNxt;
    end
  end

  // Next-state, shift/check datapath and next output values
  always_comb begin
    stateNxt    = state;
    shiftNxt    = shiftReg;
    bitCntNxt   = bitCnt;
    failCntNxt  = failCnt;
    parityNxt   = parityBit;
    keyOutNxt   = key_out;
    keyValidNxt = key_valid;
    loadErrNxt  = 1'b0;
    lockoutNxt  = lockout;

    case (state)
      IDLE: begin
        if (load_start) begin
          stateNxt  = SHIFT;
          bitCntNxt = '0;
          shiftNxt  = '0;
        end
      end
      SHIFT: begin
        if (key_sen) begin
          if (bitCnt == CNT_W'(KEY_W)) begin
            parityNxt = key_sdi;
            stateNxt  = CHECK;
          end else begin
            shiftNxt  = KEY_W'({shiftReg, key_sdi});
            bitCntNxt = bitCnt + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (^{shiftReg, parityBit} == 1'b0) begin
          keyOutNxt   = shiftReg;
          keyValidNxt = 1'b1;
          failCntNxt  = '0;
          stateNxt    = VALID;
        end else begin
          loadErrNxt = 1'b1;
          failCntNxt = failCnt + FAIL_W'(1);
          if (failCntNxt == FAIL_W'(MAX_FAIL)) begin
            lockoutNxt = 1'b1;
            stateNxt   = LOCKOUT;
          end else begin
            stateNxt = IDLE;
          end
        end
      end
      VALID: begin
        // Withdraw the old key before any new bit is shifted in
        if (load_start) begin
          keyOutNxt   = '0;
          keyValidNxt = 1'b0;
          bitCntNxt   = '0;
          shiftNxt    = '0;
          stateNxt    = SHIFT;
        end
      end
      LOCKOUT: begin
        keyOutNxt   = '0;
        keyValidNxt = 1'b0;
        lockoutNxt  = 1'b1;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase

    busyNxt = (stateNxt == SHIFT) || (stateNxt == CHECK);
  end

endmodule
